// File: rtl/cfi_log_scheduler.sv
// ============================================================================
// Module   : cfi_log_scheduler
// Purpose  : Buffers flagged CFI log entries from all commit ports and serialises
//            them onto one valid/ready stream toward the CFI checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cfi_log_scheduler_pkg;
  typedef struct packed {
    logic [31:0] addr_pc;
    logic [31:0] target_pc;
    logic [1:0]  kind;
  } cfi_log_t;
endpackage

module cfi_log_scheduler
  import cfi_log_scheduler_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8,
  parameter int DROP_CNT_W      = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic                                flush_i,
  input  logic                                clear_i,
  input  cfi_log_t [NR_COMMIT_PORTS-1:0]      log_i,
  input  logic [NR_COMMIT_PORTS-1:0]          cfi_i,
  output logic                                stall_o,
  output cfi_log_t                            log_o,
  output logic                                log_valid_o,
  input  logic                                log_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]          count_o,
  output logic                                overflow_o,
  output logic [DROP_CNT_W-1:0]               drop_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cfi_log_t                     r_mem [DEPTH];
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [CNT_W-1:0]             r_count;
  logic                         r_overflow;
  logic [DROP_CNT_W-1:0]        r_drop_cnt;

  logic [NR_COMMIT_PORTS-1:0]   w_req;
  logic [NR_COMMIT_PORTS-1:0]   w_acc;
  logic [PTR_W-1:0]             w_waddr [NR_COMMIT_PORTS];
  logic [CNT_W-1:0]             w_free;
  logic [CNT_W-1:0]             w_acc_cnt;
  logic [CNT_W-1:0]             w_drop_n;
  logic                         w_pop;
  logic [CNT_W-1:0]             w_count_nxt;
  logic [DROP_CNT_W:0]          w_drop_sum;
  logic [DROP_CNT_W-1:0]        w_drop_sat;

  // Accepted ports are always the lowest-index requesters, so the running
  // accept count doubles as the compacted slot offset.
  always_comb begin
    w_req     = cfi_i & {NR_COMMIT_PORTS{enable_i}};
    w_free    = CNT_W'(DEPTH) - r_count;
    w_acc     = '0;
    w_acc_cnt = '0;
    w_drop_n  = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      w_waddr[p] = r_wr_ptr + PTR_W'(w_acc_cnt);
      if (w_req[p]) begin
        if (w_acc_cnt < w_free) begin
          w_acc[p]  = 1'b1;
          w_acc_cnt = w_acc_cnt + CNT_W'(1);
        end else begin
          w_drop_n  = w_drop_n + CNT_W'(1);
        end
      end
    end
  end

  assign w_pop       = (r_count != '0) && log_ready_i;
  assign w_count_nxt = r_count + w_acc_cnt - CNT_W'(w_pop);
  assign w_drop_sum  = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_drop_n);
  assign w_drop_sat  = w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_acc_cnt);
        r_count  <= w_count_nxt;
      end
      // A drop in the same cycle as clear restarts the count from this drop.
      if (!flush_i && (w_drop_n != '0)) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= clear_i ? DROP_CNT_W'(w_drop_n) : w_drop_sat;
      end else if (clear_i) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
        if (w_acc[p]) begin
          r_mem[w_waddr[p]] <= log_i[p];
        end
      end
    end
  end

  assign log_valid_o = (r_count != '0);
  assign log_o       = log_valid_o ? r_mem[r_rd_ptr] : '0;
  assign count_o     = r_count;
  assign stall_o     = (w_free < CNT_W'(NR_COMMIT_PORTS));
  assign overflow_o  = r_overflow;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cfi_log_scheduler.sv
// ============================================================================
// Module   : tb_cfi_log_scheduler
// Purpose  : Directed vector bench for cfi_log_scheduler (2 ports, depth 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cfi_log_scheduler;
  import cfi_log_scheduler_pkg::*;

  localparam int NP = 2;
  localparam int DP = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b0;
  logic                 enable_i = 1'b0;
  logic                 flush_i = 1'b0;
  logic                 clear_i = 1'b0;
  cfi_log_t [NP-1:0]    log_i;
  logic [NP-1:0]        cfi_i = '0;
  logic                 stall_o;
  cfi_log_t             log_o;
  logic                 log_valid_o;
  logic                 log_ready_i = 1'b0;
  logic [2:0]           count_o;
  logic                 overflow_o;
  logic [15:0]          drop_cnt_o;

  int checks = 0;
  int errors = 0;

  cfi_log_scheduler #(.NR_COMMIT_PORTS(NP), .DEPTH(DP), .DROP_CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .clear_i(clear_i), .log_i(log_i), .cfi_i(cfi_i), .stall_o(stall_o),
    .log_o(log_o), .log_valid_o(log_valid_o), .log_ready_i(log_ready_i),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, en, flush, clear;
    logic [1:0]  cfi;
    logic        ready;
    logic [31:0] pc0, pc1;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        stall, ovf;
    logic [15:0] drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic en, logic flush, logic clear,
                              logic [1:0] cfi, logic ready, logic [31:0] pc0,
                              logic [31:0] pc1, logic vld, logic [31:0] pc,
                              logic [2:0] cnt, logic stall, logic ovf,
                              logic [15:0] drop);
    vec_t v;
    v.rst = rst; v.en = en; v.flush = flush; v.clear = clear; v.cfi = cfi;
    v.ready = ready; v.pc0 = pc0; v.pc1 = pc1; v.vld = vld; v.pc = pc;
    v.cnt = cnt; v.stall = stall; v.ovf = ovf; v.drop = drop;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp, int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    logic [31:0] exp_tgt;
    rst_i = v.rst; enable_i = v.en; flush_i = v.flush; clear_i = v.clear;
    cfi_i = v.cfi; log_ready_i = v.ready;
    log_i[0] = '{addr_pc: v.pc0, target_pc: v.pc0 + 32'h100, kind: 2'd0};
    log_i[1] = '{addr_pc: v.pc1, target_pc: v.pc1 + 32'h100, kind: 2'd1};
    @(posedge clk_i);
    #1;
    exp_tgt = v.vld ? v.pc + 32'h100 : 32'h0;
    chk("log_valid", 32'(log_valid_o), 32'(v.vld), idx);
    chk("addr_pc", log_o.addr_pc, v.pc, idx);
    chk("target_pc", log_o.target_pc, exp_tgt, idx);
    chk("count", 32'(count_o), 32'(v.cnt), idx);
    chk("stall", 32'(stall_o), 32'(v.stall), idx);
    chk("overflow", 32'(overflow_o), 32'(v.ovf), idx);
    chk("drop_cnt", 32'(drop_cnt_o), 32'(v.drop), idx);
  endtask

  initial begin
    log_i = '0;
    //          rst en fl cl cfi    rdy pc0           pc1           vld pc            cnt stl ovf drop
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b11, 1, 32'h8000_0000, 32'h8000_0004, 1, 32'h8000_0000, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 1, 32'h0,        32'h0,        1, 32'h8000_0004, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 1, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b10, 0, 32'h1111_0000, 32'h2222_0004, 1, 32'h2222_0004, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 1, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b11, 0, 32'hA000_0000, 32'hA000_0004, 1, 32'hA000_0000, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b11, 0, 32'hB000_0000, 32'hB000_0004, 1, 32'hA000_0000, 4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b11, 0, 32'hC000_0000, 32'hC000_0004, 1, 32'hA000_0000, 4, 1, 1, 2));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 1, 32'h0,        32'h0,        1, 32'hA000_0004, 3, 1, 1, 2));
    vecs.push_back(mk(0, 1, 0, 0, 2'b11, 1, 32'hD000_0000, 32'hD000_0004, 1, 32'hB000_0000, 3, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 0, 32'hE000_0000, 32'h0,        1, 32'hB000_0000, 4, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 1, 32'h0,        32'h0,        1, 32'hB000_0004, 3, 1, 1, 3));
    // Push/pop pairs at occupancy 3 walk both pointers around the ring.
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 32'hF000_0000, 32'h0,        1, 32'hD000_0000, 3, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 32'hF000_0004, 32'h0,        1, 32'hE000_0000, 3, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 32'hF000_0008, 32'h0,        1, 32'hF000_0000, 3, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 32'hF000_000C, 32'h0,        1, 32'hF000_0004, 3, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 32'hF000_0010, 32'h0,        1, 32'hF000_0008, 3, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 32'hF000_0014, 32'h0,        1, 32'hF000_000C, 3, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 0, 32'h6000_0000, 32'h0,        1, 32'hF000_000C, 4, 1, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 32'h7000_0000, 32'h0,        1, 32'hF000_0010, 3, 1, 1, 4));
    vecs.push_back(mk(0, 1, 1, 0, 2'b11, 1, 32'h1000_0000, 32'h1000_0004, 0, 32'h0,        0, 0, 1, 4));
    vecs.push_back(mk(0, 1, 0, 1, 2'b00, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b11, 0, 32'h3000_0000, 32'h3000_0004, 1, 32'h3000_0000, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b11, 0, 32'h4000_0000, 32'h4000_0004, 1, 32'h3000_0000, 4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 2'b11, 0, 32'h5000_0000, 32'h5000_0004, 1, 32'h3000_0000, 4, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 2'b11, 1, 32'h5000_0000, 32'h5000_0004, 1, 32'h3000_0004, 3, 1, 1, 2));
    vecs.push_back(mk(1, 1, 0, 0, 2'b11, 1, 32'h5000_0000, 32'h5000_0004, 0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 32'h9000_0000, 32'h0,        1, 32'h9000_0000, 1, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Head must hold steady while the checker withholds ready.
    enable_i = 1'b1; cfi_i = 2'b00; log_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
      chk("hold_addr_pc", log_o.addr_pc, 32'h9000_0000, 100 + k);
      chk("hold_count", 32'(count_o), 32'd1, 100 + k);
    end
    log_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("drain_valid", 32'(log_valid_o), 32'd0, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
